// File: rtl/bus_codes_pkg.sv
// Shared destination-code map and decoder state type.
// Used by the bus destination decoder and the bus source encoder, so both sides
// agree on which 5-bit code names which datapath register.
package bus_codes_pkg;

    localparam logic [4:0] DEST_R0      = 5'd0;
    localparam logic [4:0] DEST_R1      = 5'd1;
    localparam logic [4:0] DEST_R2      = 5'd2;
    localparam logic [4:0] DEST_R3      = 5'd3;
    localparam logic [4:0] DEST_R4      = 5'd4;
    localparam logic [4:0] DEST_R5      = 5'd5;
    localparam logic [4:0] DEST_R6      = 5'd6;
    localparam logic [4:0] DEST_R7      = 5'd7;
    localparam logic [4:0] DEST_R8      = 5'd8;
    localparam logic [4:0] DEST_R9      = 5'd9;
    localparam logic [4:0] DEST_R10     = 5'd10;
    localparam logic [4:0] DEST_R11     = 5'd11;
    localparam logic [4:0] DEST_R12     = 5'd12;
    localparam logic [4:0] DEST_R13     = 5'd13;
    localparam logic [4:0] DEST_R14     = 5'd14;
    localparam logic [4:0] DEST_R15     = 5'd15;
    localparam logic [4:0] DEST_HI      = 5'd16;
    localparam logic [4:0] DEST_LO      = 5'd17;
    localparam logic [4:0] DEST_PC      = 5'd18;
    localparam logic [4:0] DEST_MDR     = 5'd19;
    localparam logic [4:0] DEST_MAR     = 5'd20;
    localparam logic [4:0] DEST_IR      = 5'd21;
    localparam logic [4:0] DEST_Y       = 5'd22;
    localparam logic [4:0] DEST_OUTPORT = 5'd23;

    // Codes above this are reserved and rejected.
    localparam logic [4:0] DEST_LAST_LEGAL = 5'd23;

    typedef enum logic [1:0] {
        StIdle,
        StSingle,
        StPairFirst,
        StPairSecond
    } dest_state_e;

endpackage

// File: rtl/decoder_5_to_32.sv
// Combinational 5-to-32 one-hot decoder.
// Ports:
//   en     - gates every output; all zeros when low
//   code   - 5-bit select
//   onehot - bit [code] high when en is high
module decoder_5_to_32 (
    input  logic        en,
    input  logic [4:0]  code,
    output logic [31:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[code] = 1'b1;
        end
    end

endmodule

// File: rtl/bus_dest_decoder.sv
// Bus destination decoder: turns an accepted 5-bit destination code into a
// registered, single-cycle, one-hot load enable, and sequences the two-cycle
// ZHI/ZLO -> HI/LO result transfer used after mul/div.
// Ports:
//   clock, reset          - rising-edge clock, async active-high reset
//   dest_valid/dest_ready - request handshake; ready is high only when idle
//   dest_code, pair_load  - captured at acceptance
//   r_in .. outport_in    - registered load enables (at most one high)
//   zhi_out, zlo_out      - bus encoder source selects during a pair transfer
//   done                  - pulse in the final load cycle of a legal request
//   illegal               - pulse after a rejected code
module bus_dest_decoder
    import bus_codes_pkg::*;
#(
    parameter bit R0_WRITABLE   = 1'b1,
    parameter bit PAIR_HI_FIRST = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        dest_valid,
    output logic        dest_ready,
    input  logic [4:0]  dest_code,
    input  logic        pair_load,
    output logic [15:0] r_in,
    output logic        hi_in,
    output logic        lo_in,
    output logic        pc_in,
    output logic        mdr_in,
    output logic        mar_in,
    output logic        ir_in,
    output logic        y_in,
    output logic        outport_in,
    output logic        zhi_out,
    output logic        zlo_out,
    output logic        done,
    output logic        illegal
);

    dest_state_e state_q, state_d;

    logic        accept;
    logic        legal;
    logic        single_go;
    logic [31:0] onehot;
    logic        unused_dec;

    logic        pair_hi_d, pair_lo_d;
    logic        done_d, illegal_d;
    logic [23:0] load_d, load_q;
    logic        zhi_q, zlo_q, done_q, illegal_q, ready_q;

    assign accept    = dest_valid && ready_q;
    assign legal     = (dest_code <= DEST_LAST_LEGAL) &&
                       (R0_WRITABLE || (dest_code != DEST_R0));
    assign single_go = accept && !pair_load && legal;

    // Decoding the live code at acceptance and registering the result is what
    // captures the code: later changes on dest_code cannot reach the enables.
    decoder_5_to_32 u_dec (
        .en     (single_go),
        .code   (dest_code),
        .onehot (onehot)
    );

    assign unused_dec = ^onehot[31:24];

    always_comb begin
        state_d   = state_q;
        pair_hi_d = 1'b0;
        pair_lo_d = 1'b0;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (pair_load) begin
                        state_d = StPairFirst;
                        if (PAIR_HI_FIRST) pair_hi_d = 1'b1;
                        else               pair_lo_d = 1'b1;
                    end else if (legal) begin
                        state_d = StSingle;
                        done_d  = 1'b1;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            StSingle: state_d = StIdle;
            StPairFirst: begin
                state_d = StPairSecond;
                done_d  = 1'b1;
                if (PAIR_HI_FIRST) pair_lo_d = 1'b1;
                else               pair_hi_d = 1'b1;
            end
            StPairSecond: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        load_d          = onehot[23:0];
        load_d[DEST_HI] = onehot[DEST_HI] | pair_hi_d;
        load_d[DEST_LO] = onehot[DEST_LO] | pair_lo_d;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            load_q    <= '0;
            zhi_q     <= 1'b0;
            zlo_q     <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            load_q    <= load_d;
            zhi_q     <= pair_hi_d;
            zlo_q     <= pair_lo_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
            ready_q   <= (state_d == StIdle);
        end
    end

    assign dest_ready = ready_q;
    assign r_in       = load_q[15:0];
    assign hi_in      = load_q[DEST_HI];
    assign lo_in      = load_q[DEST_LO];
    assign pc_in      = load_q[DEST_PC];
    assign mdr_in     = load_q[DEST_MDR];
    assign mar_in     = load_q[DEST_MAR];
    assign ir_in      = load_q[DEST_IR];
    assign y_in       = load_q[DEST_Y];
    assign outport_in = load_q[DEST_OUTPORT];
    assign zhi_out    = zhi_q;
    assign zlo_out    = zlo_q;
    assign done       = done_q;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_bus_dest_decoder.sv
// Directed, scoreboarded bench for bus_dest_decoder. Two instances: defaults,
// and one with R0 unwritable and LO-first pair order. Outputs are packed as
// {illegal, done, ready, zhi, zlo, enables[23:0]} with enable bit n = code n.
module tb_bus_dest_decoder;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic        va, pa, vb, pb;
    logic [4:0]  ca, cb;

    logic        rdy_a, hi_a, lo_a, pc_a, mdr_a, mar_a, ir_a, y_a, op_a;
    logic        zhi_a, zlo_a, done_a, ill_a;
    logic [15:0] r_a;
    logic        rdy_b, hi_b, lo_b, pc_b, mdr_b, mar_b, ir_b, y_b, op_b;
    logic        zhi_b, zlo_b, done_b, ill_b;
    logic [15:0] r_b;

    bus_dest_decoder dut_a (
        .clock(clock), .reset(reset), .dest_valid(va), .dest_ready(rdy_a),
        .dest_code(ca), .pair_load(pa), .r_in(r_a), .hi_in(hi_a), .lo_in(lo_a),
        .pc_in(pc_a), .mdr_in(mdr_a), .mar_in(mar_a), .ir_in(ir_a), .y_in(y_a),
        .outport_in(op_a), .zhi_out(zhi_a), .zlo_out(zlo_a), .done(done_a),
        .illegal(ill_a)
    );

    bus_dest_decoder #(.R0_WRITABLE(1'b0), .PAIR_HI_FIRST(1'b0)) dut_b (
        .clock(clock), .reset(reset), .dest_valid(vb), .dest_ready(rdy_b),
        .dest_code(cb), .pair_load(pb), .r_in(r_b), .hi_in(hi_b), .lo_in(lo_b),
        .pc_in(pc_b), .mdr_in(mdr_b), .mar_in(mar_b), .ir_in(ir_b), .y_in(y_b),
        .outport_in(op_b), .zhi_out(zhi_b), .zlo_out(zlo_b), .done(done_b),
        .illegal(ill_b)
    );

    logic [28:0] obs_a, obs_b;
    assign obs_a = {ill_a, done_a, rdy_a, zhi_a, zlo_a, op_a, y_a, ir_a, mar_a, mdr_a, pc_a,
                    lo_a, hi_a, r_a};
    assign obs_b = {ill_b, done_b, rdy_b, zhi_b, zlo_b, op_b, y_b, ir_b, mar_b, mdr_b, pc_b,
                    lo_b, hi_b, r_b};

    localparam logic [28:0] HI   = 29'h000_10000;
    localparam logic [28:0] LO   = 29'h000_20000;
    localparam logic [28:0] OUTP = 29'h080_0000;
    localparam logic [28:0] ZLO  = 29'h100_0000;
    localparam logic [28:0] ZHI  = 29'h200_0000;
    localparam logic [28:0] RDY  = 29'h400_0000;
    localparam logic [28:0] DONE = 29'h800_0000;
    localparam logic [28:0] ILL  = 29'h1000_0000;
    localparam logic [28:0] ALL  = 29'h1FFF_FFFF;

    logic [28:0] exp_q[$];
    int vectors = 0;
    int miscompares = 0;

    function automatic logic [28:0] bit_at(input int n);
        return 29'(1) << n;
    endfunction

    task automatic check_now(input string tag, input logic [28:0] mask, input bit sel_b);
        logic [28:0] obs, e;
        obs = (sel_b ? obs_b : obs_a) & mask;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                miscompares++;
                $error("FAIL %s: observed %h expected %h", tag, obs, e);
            end
        end
    endtask

    task automatic check_cycle(input string tag, input logic [28:0] mask, input bit sel_b);
        @(posedge clock);
        #1;
        check_now(tag, mask, sel_b);
    endtask

    // Drive instance A for one edge and score the registered result of that edge.
    task automatic apply(input logic v, input logic [4:0] c, input logic p,
                         input logic [28:0] e, input string tag);
        va = v; ca = c; pa = p;
        exp_q.push_back(e);
        check_cycle(tag, ALL, 1'b0);
    endtask

    task automatic apply_b(input logic v, input logic [4:0] c, input logic p,
                           input logic [28:0] e, input string tag);
        vb = v; cb = c; pb = p;
        exp_q.push_back(e);
        check_cycle(tag, ALL, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        va = 1'b0; ca = 5'd0; pa = 1'b0;
        vb = 1'b0; cb = 5'd0; pb = 1'b0;

        // Reset held: everything except ready is zero.
        @(posedge clock); #1;
        exp_q.push_back('0);
        check_now("reset_a", ~RDY, 1'b0);
        exp_q.push_back('0);
        check_now("reset_b", ~RDY, 1'b1);
        @(posedge clock); #1;
        reset = 1'b0;

        for (int i = 0; i < 10; i++) apply(1'b0, 5'd0, 1'b0, RDY, "idle");

        // Single loads, including boundary codes.
        apply(1'b1, 5'd5, 1'b0, bit_at(5) | DONE, "single_r5");
        apply(1'b0, 5'd0, 1'b0, RDY, "single_r5_after");
        apply(1'b1, 5'd16, 1'b0, HI | DONE, "single_hi");
        apply(1'b0, 5'd0, 1'b0, RDY, "single_hi_after");
        apply(1'b1, 5'd23, 1'b0, OUTP | DONE, "single_outport");
        apply(1'b0, 5'd0, 1'b0, RDY, "single_outport_after");
        apply(1'b1, 5'd0, 1'b0, bit_at(0) | DONE, "single_r0");
        apply(1'b0, 5'd0, 1'b0, RDY, "single_r0_after");
        for (int c = 15; c <= 22; c++) begin
            apply(1'b1, 5'(c), 1'b0, bit_at(c) | DONE, "single_sweep");
            apply(1'b0, 5'd0, 1'b0, RDY, "single_sweep_after");
        end

        // Pair transfer, code ignored.
        apply(1'b1, 5'd7, 1'b1, ZHI | HI, "pair_first");
        apply(1'b0, 5'd0, 1'b0, ZLO | LO | DONE, "pair_second");
        apply(1'b0, 5'd0, 1'b0, RDY, "pair_ready");

        // Reserved code, then back-to-back legal request.
        apply(1'b1, 5'd29, 1'b0, ILL | RDY, "illegal_29");
        apply(1'b0, 5'd0, 1'b0, RDY, "illegal_29_after");
        apply(1'b1, 5'd24, 1'b0, ILL | RDY, "illegal_24");
        apply(1'b1, 5'd5, 1'b0, bit_at(5) | DONE, "b2b_after_illegal");
        apply(1'b0, 5'd0, 1'b0, RDY, "b2b_after_illegal_idle");

        // Inputs changed and held while a pair is busy.
        apply(1'b1, 5'd0, 1'b1, ZHI | HI, "hold_pair_first");
        apply(1'b1, 5'd3, 1'b0, ZLO | LO | DONE, "hold_pair_second");
        apply(1'b1, 5'd3, 1'b0, RDY, "hold_not_accepted");
        apply(1'b1, 5'd3, 1'b0, bit_at(3) | DONE, "hold_accepted");
        apply(1'b0, 5'd0, 1'b0, RDY, "hold_once_1");
        apply(1'b0, 5'd0, 1'b0, RDY, "hold_once_2");

        // Reset during the first half of a pair.
        apply(1'b1, 5'd0, 1'b1, ZHI | HI, "midreset_first");
        va = 1'b0; pa = 1'b0;
        reset = 1'b1;
        #1;
        exp_q.push_back('0);
        check_now("midreset_async_drop", ~RDY, 1'b0);
        exp_q.push_back('0);
        check_cycle("midreset_no_second", ~RDY, 1'b0);
        reset = 1'b0;
        apply(1'b0, 5'd0, 1'b0, RDY, "midreset_ready");
        apply(1'b0, 5'd0, 1'b0, RDY, "midreset_no_done");
        apply(1'b1, 5'd9, 1'b0, bit_at(9) | DONE, "midreset_recover");
        apply(1'b0, 5'd0, 1'b0, RDY, "midreset_recover_idle");

        // Instance B: R0 unwritable, LO-first pair order.
        apply_b(1'b1, 5'd0, 1'b0, ILL | RDY, "nr0_code0");
        apply_b(1'b0, 5'd0, 1'b0, RDY, "nr0_code0_after");
        apply_b(1'b1, 5'd1, 1'b0, bit_at(1) | DONE, "nr0_r1");
        apply_b(1'b0, 5'd0, 1'b0, RDY, "nr0_r1_after");
        apply_b(1'b1, 5'd0, 1'b1, ZLO | LO, "lofirst_first");
        apply_b(1'b0, 5'd0, 1'b0, ZHI | HI | DONE, "lofirst_second");
        apply_b(1'b0, 5'd0, 1'b0, RDY, "lofirst_ready");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bus_dest_decoder.md
Name: bus_dest_decoder

Overview:
- Write-side counterpart of the bus source encoder/mux. Takes a 5-bit destination code and produces one-hot, single-cycle load enables for the register that captures BusMuxOut.
- Also sequences the two-cycle 64-bit result transfer used after mul/div: ZHI to HI, then ZLO to LO. For this transfer it drives the matching source select for the bus encoder.
- Sits between the control unit and the register enables of the datapath.

Parameters:
- R0_WRITABLE, 1, when 0, destination code 0 is treated as illegal and R0 is never loaded.
- PAIR_HI_FIRST, 1, when 1 a pair transfer does HI then LO; when 0 it does LO then HI.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- dest_valid  in  1  request strobe; held by the requester until accepted.
- dest_ready  out  1  high only in IDLE; a request is accepted when dest_valid && dest_ready at a rising edge.
- dest_code  in  5  destination select: 0-15 R0-R15, 16 HI, 17 LO, 18 PC, 19 MDR, 20 MAR, 21 IR, 22 Y, 23 OutPort, 24-31 reserved.
- pair_load  in  1  sampled with dest_valid; when 1, dest_code is ignored and a ZHI/ZLO to HI/LO pair transfer is run.
- r_in  out  16  load enables for R0-R15.
- hi_in, lo_in, pc_in, mdr_in, mar_in, ir_in, y_in, outport_in  out  1 each  load enables.
- zhi_out, zlo_out  out  1 each  source selects to the bus encoder during a pair transfer.
- done  out  1  one-cycle pulse in the final load cycle of every accepted legal request.
- illegal  out  1  one-cycle pulse for a rejected code.

Behaviour:
- Reset: asynchronous and active-high, as already decided. While reset is high, every output is 0 except dest_ready. The state is forced to IDLE. dest_ready goes to 1 on the first clock after reset deasserts.
- All outputs are registered. Enables assert in the cycle after acceptance, never combinationally from the inputs.
- States: IDLE, SINGLE, PAIR_FIRST, PAIR_SECOND.
- IDLE, accept with pair_load=0 and a legal code:
  - Go to SINGLE.
  - In SINGLE exactly one enable bit is high, the one decoded from the captured code, and done=1.
  - Next state is IDLE.
- IDLE, accept with pair_load=0 and code 24-31, or code 0 with R0_WRITABLE=0:
  - Stay in IDLE.
  - illegal=1 for the next cycle only.
  - No enable asserts and done stays 0.
  - dest_ready stays high, so a back-to-back request is accepted.
- IDLE, accept with pair_load=1:
  - PAIR_FIRST: zhi_out=1 and hi_in=1. With PAIR_HI_FIRST=0 it is zlo_out/lo_in instead.
  - PAIR_SECOND: the complementary pair, plus done=1.
  - Next state is IDLE.
- Throughput: a single load occupies 2 cycles (accept plus SINGLE); a pair occupies 3. dest_ready is 0 in SINGLE, PAIR_FIRST and PAIR_SECOND.
- dest_code and pair_load are captured at acceptance. Changes to them while busy have no effect.
- Invariants:
  - At most one load enable is high in any cycle.
  - At most one of zhi_out and zlo_out is high.
  - done and illegal are never high together.
- Reset mid-operation, for example in PAIR_FIRST: all enables drop immediately and asynchronously, the second half is not performed, and no done is issued.

Decomposition:
- Shared package bus_codes_pkg:
  - 5-bit destination-code constants, DEST_R0 through DEST_OUTPORT.
  - DEST_LAST_LEGAL = 23.
  - State enum.
  - The package is shared with the source encoder so the code maps stay aligned.
- Sub-module decoder_5_to_32: a combinational one-hot decoder whose enable input gates all outputs.
- Top level: the FSM, the capture registers, and the output registers that map one-hot bits 0-23 onto the enable ports.

Test Plan:
- Reset then idle: reset pulse with dest_valid=0 → all enables 0, dest_ready=1, no done or illegal for 10 cycles.
- Single loads: dest_code=5, then 16, then 23, each accepted → the cycle after each accept has r_in=16'h0020, then hi_in=1, then outport_in=1, each with done=1 for exactly 1 cycle; dest_ready=0 during that cycle.
- Pair transfer: pair_load=1 with dest_code=7 (ignored) → cycle+1 zhi_out=hi_in=1; cycle+2 zlo_out=lo_in=1 and done=1; r_in stays 0; dest_ready returns 1 at cycle+3.
- Illegal codes: dest_code=29 → illegal=1 for 1 cycle, no enable. Then with R0_WRITABLE=0, dest_code=0 → illegal=1 and r_in=0.
- Hold while busy: during a pair transfer, change dest_code to 3 and keep dest_valid high → ignored until IDLE, then accepted once, so r_in=16'h0008 appears once.
- Reset mid-pair: assert reset during PAIR_FIRST → hi_in and zhi_out drop the same cycle; PAIR_SECOND never occurs; no done; the next request after reset completes normally.
